addsub_ctrl: RTL and testbench

Operand-entry and result-capture controller wrapped around the 4-bit add/subtract unit. It collects operand A, operand B and the operation select from a shared switch bus using single-cycle load pulses, and drives them onto the adder's a/b/sel inputs. It then registers the adder's sum/cout with a signed-overflow flag for display. Sits between the board input conditioning (debounced one-pulse keys) and the AddSub datapath/LED outputs.

---
 rtl/addsub_ctrl.sv | 147 ++++++++++++++
 tb/tb_addsub_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_ctrl.sv
// Operand-entry and result-capture controller for the 4-bit AddSub unit.
// Collects A, B and the op select from a shared switch bus, then registers sum/cout/overflow.
module addsub_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             key_load,
  input  logic             key_clear,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             sel,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             result_ovf,
  output logic             result_valid,
  output logic [3:0]       op_count,
  output logic [2:0]       state
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_cout_q, result_cout_d;
  logic             result_ovf_q, result_ovf_d;
  logic             result_valid_q, result_valid_d;
  logic [3:0]       op_count_q, op_count_d;
  logic             ovf_calc;

  // Signed overflow: operands that agree in sign (add) or disagree (subtract)
  // overflow when the sum's sign departs from A's.
  always_comb begin
    if (sel_q) ovf_calc = (a_q[MSB] != b_q[MSB]) && (sum_in[MSB] != a_q[MSB]);
    else       ovf_calc = (a_q[MSB] == b_q[MSB]) && (sum_in[MSB] != a_q[MSB]);
  end

  // Handshake: key_load/key_clear are one-cycle pulses with no ready; each high
  // cycle is one event. result_valid stays high from capture until the next A load.
  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    sel_d          = sel_q;
    result_d       = result_q;
    result_cout_d  = result_cout_q;
    result_ovf_d   = result_ovf_q;
    result_valid_d = result_valid_q;
    op_count_d     = op_count_q;
    if (key_clear) begin
      state_d        = S_A;
      a_d            = '0;
      b_d            = '0;
      sel_d          = 1'b0;
      result_d       = '0;
      result_cout_d  = 1'b0;
      result_ovf_d   = 1'b0;
      result_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (key_load) begin
            a_d     = din;
            state_d = S_B;
          end
        end
        S_B: begin
          if (key_load) begin
            b_d     = din;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (key_load) begin
            sel_d   = din[0];
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          result_d       = sum_in;
          result_cout_d  = cout_in;
          result_ovf_d   = ovf_calc;
          result_valid_d = 1'b1;
          op_count_d     = op_count_q + 4'd1;
          state_d        = S_DONE;
        end
        S_DONE: begin
          if (key_load) begin
            result_valid_d = 1'b0;
            a_d            = din;
            state_d        = S_B;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_A;
      a_q            <= '0;
      b_q            <= '0;
      sel_q          <= 1'b0;
      result_q       <= '0;
      result_cout_q  <= 1'b0;
      result_ovf_q   <= 1'b0;
      result_valid_q <= 1'b0;
      op_count_q     <= 4'd0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      sel_q          <= sel_d;
      result_q       <= result_d;
      result_cout_q  <= result_cout_d;
      result_ovf_q   <= result_ovf_d;
      result_valid_q <= result_valid_d;
      op_count_q     <= op_count_d;
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign sel          = sel_q;
  assign result       = result_q;
  assign result_cout  = result_cout_q;
  assign result_ovf   = result_ovf_q;
  assign result_valid = result_valid_q;
  assign op_count     = op_count_q;
  assign state        = state_q;

endmodule

// File: tb/tb_addsub_ctrl.sv
// Bench for addsub_ctrl: AddSub behavioural stand-in, arithmetic reference model,
// per-cycle compare, result scoreboard and directed literal checks.
module tb_addsub_ctrl;

  localparam int WIDTH = 4;
  localparam int SBW   = WIDTH + 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             key_load;
  logic             key_clear;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic [WIDTH-1:0] result;
  logic             result_cout;
  logic             result_ovf;
  logic             result_valid;
  logic [3:0]       op_count;
  logic [2:0]       state;

  addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .din(din), .key_load(key_load), .key_clear(key_clear),
    .sum_in(sum_in), .cout_in(cout_in), .a(a), .b(b), .sel(sel),
    .result(result), .result_cout(result_cout), .result_ovf(result_ovf),
    .result_valid(result_valid), .op_count(op_count), .state(state)
  );

  // AddSub stand-in: subtract is a + ~b + 1, so carry-out 1 means no borrow.
  logic [WIDTH:0] addsub_full;
  assign addsub_full = sel ? ({1'b0, a} + {1'b0, ~b} + 1'b1) : ({1'b0, a} + {1'b0, b});
  assign sum_in  = addsub_full[WIDTH-1:0];
  assign cout_in = addsub_full[WIDTH];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int signed_of(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? int'(v) - (1 << WIDTH) : int'(v);
  endfunction

  function automatic logic [SBW-1:0] calc(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                          input logic op);
    int r, s;
    logic c, o;
    if (op) begin
      r = (int'(x) - int'(y) + (1 << WIDTH)) % (1 << WIDTH);
      c = (x >= y);
      s = signed_of(x) - signed_of(y);
    end else begin
      r = (int'(x) + int'(y)) % (1 << WIDTH);
      c = (int'(x) + int'(y)) >= (1 << WIDTH);
      s = signed_of(x) + signed_of(y);
    end
    o = (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
    return {o, c, r[WIDTH-1:0]};
  endfunction

  // phase counts entry steps: 0 A, 1 B, 2 op, 3 executing, 4 showing result
  int               m_phase = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic             m_sel = 1'b0, m_cout = 1'b0, m_ovf = 1'b0, m_valid = 1'b0;
  int               m_count = 0;
  logic [SBW-1:0]   exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_a <= '0; m_b <= '0; m_sel <= 1'b0;
      m_res <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_valid <= 1'b0; m_count <= 0;
      exp_q.delete();
    end else if (key_clear) begin
      m_phase <= 0; m_a <= '0; m_b <= '0; m_sel <= 1'b0;
      m_res <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_valid <= 1'b0;
    end else if (m_phase == 3) begin
      logic [SBW-1:0] r;
      r = calc(m_a, m_b, m_sel);
      {m_ovf, m_cout, m_res} <= r;
      exp_q.push_back(r);
      m_valid <= 1'b1;
      m_count <= (m_count + 1) % 16;
      m_phase <= 4;
    end else if (key_load) begin
      if (m_phase == 0 || m_phase == 4) begin
        m_a <= din; m_valid <= 1'b0; m_phase <= 1;
      end else if (m_phase == 1) begin
        m_b <= din; m_phase <= 2;
      end else begin
        m_sel <= din[0]; m_phase <= 3;
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("state", {5'd0, state}, 8'(m_phase));
      check("a", {4'd0, a}, {4'd0, m_a});
      check("b", {4'd0, b}, {4'd0, m_b});
      check("sel", {7'd0, sel}, {7'd0, m_sel});
      check("result", {4'd0, result}, {4'd0, m_res});
      check("result_cout", {7'd0, result_cout}, {7'd0, m_cout});
      check("result_ovf", {7'd0, result_ovf}, {7'd0, m_ovf});
      check("result_valid", {7'd0, result_valid}, {7'd0, m_valid});
      check("op_count", {4'd0, op_count}, 8'(m_count));
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 8'd1, 8'd0);
        end else begin
          logic [SBW-1:0] e;
          e = exp_q.pop_front();
          check("sb_result", {2'd0, result_ovf, result_cout, result}, {2'd0, e});
        end
      end
    end
    prev_valid = result_valid;
  end

  // ---------------- driver tasks (start/end at posedge+2) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_load(input logic [WIDTH-1:0] v);
    din = v;
    key_load = 1'b1;
    idle(1);
    key_load = 1'b0;
  endtask

  task automatic pulse_clear();
    key_clear = 1'b1;
    idle(1);
    key_clear = 1'b0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic op);
    pulse_load(x);
    pulse_load(y);
    pulse_load({3'd0, op});
    idle(1);
  endtask

  task automatic check_result(input string tag, input logic [3:0] r, input logic c,
                              input logic o, input logic [3:0] cnt);
    check({tag, "_result"}, {4'd0, result}, {4'd0, r});
    check({tag, "_cout"}, {7'd0, result_cout}, {7'd0, c});
    check({tag, "_ovf"}, {7'd0, result_ovf}, {7'd0, o});
    check({tag, "_valid"}, {7'd0, result_valid}, 8'd1);
    check({tag, "_count"}, {4'd0, op_count}, {4'd0, cnt});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; din = '0; key_load = 1'b0; key_clear = 1'b0;
    idle(2);
    rst = 1'b0;
    check("rst_state", {5'd0, state}, 8'd0);
    check("rst_valid", {7'd0, result_valid}, 8'd0);
    check("rst_count", {4'd0, op_count}, 8'd0);
    cmp_en = 1'b1;

    pulse_load(4'd5);
    check("after_a_state", {5'd0, state}, 8'd1);
    pulse_load(4'd1);
    pulse_load(4'd0);
    check("exec_state", {5'd0, state}, 8'd3);
    check("exec_valid", {7'd0, result_valid}, 8'd0);
    idle(1);
    check("op1_a", {4'd0, a}, 8'd5);
    check("op1_b", {4'd0, b}, 8'd1);
    check("op1_sel", {7'd0, sel}, 8'd0);
    check_result("op1", 4'd6, 1'b0, 1'b0, 4'd1);
    check("done_state", {5'd0, state}, 8'd4);

    run_op(4'd5, 4'd1, 1'b1);
    check_result("op2", 4'd4, 1'b1, 1'b0, 4'd2);
    run_op(4'd1, 4'd5, 1'b1);
    check_result("op3", 4'd12, 1'b0, 1'b0, 4'd3);
    run_op(4'd7, 4'd1, 1'b0);
    check_result("op4", 4'd8, 1'b0, 1'b1, 4'd4);
    run_op(4'd8, 4'd1, 1'b1);
    check_result("op5", 4'd7, 1'b1, 1'b1, 4'd5);

    // clear and load together in the B step: clear wins
    pulse_load(4'd2);
    din = 4'd9; key_load = 1'b1; key_clear = 1'b1;
    idle(1);
    key_load = 1'b0; key_clear = 1'b0;
    check("clr_load_state", {5'd0, state}, 8'd0);
    check("clr_load_a", {4'd0, a}, 8'd0);
    check("clr_load_b", {4'd0, b}, 8'd0);

    // clear during execute aborts the capture
    pulse_load(4'd3); pulse_load(4'd4); pulse_load(4'd1);
    pulse_clear();
    idle(1);
    check("clr_exec_valid", {7'd0, result_valid}, 8'd0);
    check("clr_exec_count", {4'd0, op_count}, 8'd5);
    check("clr_exec_state", {5'd0, state}, 8'd0);

    // asynchronous reset in the middle of execute
    pulse_load(4'd2); pulse_load(4'd2); pulse_load(4'd0);
    #1 rst = 1'b1;
    #1;
    check("arst_state", {5'd0, state}, 8'd0);
    check("arst_a", {4'd0, a}, 8'd0);
    check("arst_b", {4'd0, b}, 8'd0);
    check("arst_sel", {7'd0, sel}, 8'd0);
    check("arst_result", {4'd0, result}, 8'd0);
    check("arst_flags", {5'd0, result_cout, result_ovf, result_valid}, 8'd0);
    check("arst_count", {4'd0, op_count}, 8'd0);
    #2 rst = 1'b0;
    idle(1);

    for (int i = 0; i < 16; i++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    check("wrap_count", {4'd0, op_count}, 8'd0);

    // random key traffic, including held keys and clear/load collisions
    for (int i = 0; i < 600; i++) begin
      din       = 4'($urandom_range(0, 15));
      key_load  = ($urandom_range(0, 99) < 45);
      key_clear = ($urandom_range(0, 99) < 4);
      idle(1);
    end
    key_load = 1'b0; key_clear = 1'b0;
    idle(3);
    check("sb_drained", 8'(exp_q.size()), 8'd0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
